// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: owns the fetch PC, picks PC+4 / branch / jump target and holds it on memory busywait.
// Optional commit statistics (INSTR_CNT, BR_TAKEN_CNT) are compiled in when BRANCH_STATS_EN is defined.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          STALL_TIMEOUT = 255,
  parameter int          CNT_W         = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  input  logic        BRANCH,
  input  logic        BRANCHNOT,
  input  logic        JUMP,
  input  logic        ZERO,
  input  logic [7:0]  RD_OFFSET,
  output logic [31:0] PC,
  output logic        FETCH_REQ,
  output logic        STALL,
  output logic        TAKEN,
`ifdef BRANCH_STATS_EN
  output logic [15:0] BR_TAKEN_CNT,
  output logic [15:0] INSTR_CNT,
`endif
  output logic        TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STALL,
    ST_HALT
  } state_t;

  localparam bit               WDOG_EN   = (STALL_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;
  logic             busy;
  logic             take;
  logic             commit;
  logic             taken_nxt;
  logic             timeout_nxt;
  logic [31:0]      pc_plus4;
  logic [31:0]      offset_ext;
  logic [31:0]      target;
  logic [31:0]      next_pc;

  assign busy       = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign take       = JUMP | (BRANCH & ZERO) | (BRANCHNOT & ~ZERO);
  assign pc_plus4   = PC + 32'd4;
  // Word offset: sign-extend and scale by 4 before adding to the fall-through address.
  assign offset_ext = {{22{RD_OFFSET[7]}}, RD_OFFSET, 2'b00};
  assign target     = pc_plus4 + offset_ext;
  assign next_pc    = take ? target : pc_plus4;

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    commit        = 1'b0;
    taken_nxt     = 1'b0;
    timeout_nxt   = TIMEOUT_ERR;
    FETCH_REQ     = 1'b0;
    STALL         = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        FETCH_REQ = 1'b1;
        if (busy) begin
          STALL         = 1'b1;
          stall_cnt_nxt = CNT_ONE;
          state_nxt     = ST_STALL;
        end else begin
          commit    = 1'b1;
          taken_nxt = take;
        end
      end
      ST_STALL: begin
        FETCH_REQ = 1'b1;
        if (!busy) begin
          commit        = 1'b1;
          taken_nxt     = take;
          stall_cnt_nxt = '0;
          state_nxt     = ST_RUN;
        end else begin
          STALL = 1'b1;
          if (WDOG_EN && (stall_cnt == TIMEOUT_V)) begin
            state_nxt   = ST_HALT;
            timeout_nxt = 1'b1;
          end else if (stall_cnt != '1) begin
            stall_cnt_nxt = stall_cnt + CNT_ONE;
          end
        end
      end
      ST_HALT: begin
        STALL = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      stall_cnt   <= '0;
      PC          <= RESET_VECTOR;
      TAKEN       <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_cnt   <= stall_cnt_nxt;
      TAKEN       <= taken_nxt;
      TIMEOUT_ERR <= timeout_nxt;
      if (commit) begin
        PC <= next_pc;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Counters only move on commits, so they naturally freeze while stalled or halted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      INSTR_CNT    <= 16'h0000;
      BR_TAKEN_CNT <= 16'h0000;
    end else begin
      if (commit && (INSTR_CNT != 16'hFFFF)) begin
        INSTR_CNT <= INSTR_CNT + 16'd1;
      end
      if (commit && take && (BR_TAKEN_CNT != 16'hFFFF)) begin
        BR_TAKEN_CNT <= BR_TAKEN_CNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller: directed-vector bench for pc_fetch_controller (watchdog shortened to 4 cycles).
module tb_pc_fetch_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        DMEM_BUSYWAIT = 1'b0;
  logic        BRANCH = 1'b0;
  logic        BRANCHNOT = 1'b0;
  logic        JUMP = 1'b0;
  logic        ZERO = 1'b0;
  logic [7:0]  RD_OFFSET = 8'h00;
  logic [31:0] PC;
  logic        FETCH_REQ;
  logic        STALL;
  logic        TAKEN;
  logic        TIMEOUT_ERR;
`ifdef BRANCH_STATS_EN
  logic [15:0] BR_TAKEN_CNT;
  logic [15:0] INSTR_CNT;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  pc_fetch_controller #(
    .RESET_VECTOR (32'h0000_0000),
    .STALL_TIMEOUT(4),
    .CNT_W        (8)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .BRANCH       (BRANCH),
    .BRANCHNOT    (BRANCHNOT),
    .JUMP         (JUMP),
    .ZERO         (ZERO),
    .RD_OFFSET    (RD_OFFSET),
    .PC           (PC),
    .FETCH_REQ    (FETCH_REQ),
    .STALL        (STALL),
    .TAKEN        (TAKEN),
`ifdef BRANCH_STATS_EN
    .BR_TAKEN_CNT (BR_TAKEN_CNT),
    .INSTR_CNT    (INSTR_CNT),
`endif
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl;
    BRANCH    = 1'b0;
    BRANCHNOT = 1'b0;
    JUMP      = 1'b0;
    ZERO      = 1'b0;
    RD_OFFSET = 8'h00;
  endtask

  task automatic test_reset;
    clear_ctrl();
    #1 RESET = 1'b0;
    #11;
    check_cnt++;
    if ({PC, FETCH_REQ, STALL, TAKEN, TIMEOUT_ERR} !== {32'h0, 4'b0000})
      $display("[TB] FAIL reset_values: got %h, expected %h",
               {PC, FETCH_REQ, STALL, TAKEN, TIMEOUT_ERR}, {32'h0, 4'b0000});
    else pass_cnt++;
    RESET = 1'b1;
    #1;
    check_cnt++;
    if ({PC, FETCH_REQ, STALL} !== {32'h0, 2'b00})
      $display("[TB] FAIL idle_state: got %h, expected %h", {PC, FETCH_REQ, STALL}, {32'h0, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_sequential;
    tick();
    check_cnt++;
    if ({PC, FETCH_REQ, TAKEN} !== {32'h0, 2'b10})
      $display("[TB] FAIL run_entry: got %h, expected %h", {PC, FETCH_REQ, TAKEN}, {32'h0, 2'b10});
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_cnt++;
      if ({PC, FETCH_REQ, TAKEN} !== {32'(4 * i), 2'b10})
        $display("[TB] FAIL seq_pc%0d: got %h, expected %h", i, {PC, FETCH_REQ, TAKEN}, {32'(4 * i), 2'b10});
      else pass_cnt++;
    end
  endtask

  task automatic test_branch;
    tick();
    check_cnt++;
    if (PC !== 32'h10) $display("[TB] FAIL pc_0x10: got %h, expected %h", PC, 32'h10);
    else pass_cnt++;
    BRANCH = 1'b1; ZERO = 1'b1; RD_OFFSET = 8'hFE;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h0C, 1'b1})
      $display("[TB] FAIL beq_taken: got %h, expected %h", {PC, TAKEN}, {32'h0C, 1'b1});
    else pass_cnt++;
    clear_ctrl();
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h10, 1'b0})
      $display("[TB] FAIL back_to_0x10: got %h, expected %h", {PC, TAKEN}, {32'h10, 1'b0});
    else pass_cnt++;
    BRANCH = 1'b1; ZERO = 1'b0; RD_OFFSET = 8'hFE;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h14, 1'b0})
      $display("[TB] FAIL beq_not_taken: got %h, expected %h", {PC, TAKEN}, {32'h14, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_jump;
    clear_ctrl();
    JUMP = 1'b1; RD_OFFSET = 8'h02;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h20, 1'b1})
      $display("[TB] FAIL jump_to_0x20: got %h, expected %h", {PC, TAKEN}, {32'h20, 1'b1});
    else pass_cnt++;
    RD_OFFSET = 8'h03;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h30, 1'b1})
      $display("[TB] FAIL jump_0x30: got %h, expected %h", {PC, TAKEN}, {32'h30, 1'b1});
    else pass_cnt++;
    clear_ctrl();
    BRANCHNOT = 1'b1; ZERO = 1'b0; RD_OFFSET = 8'h01;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h38, 1'b1})
      $display("[TB] FAIL bne_taken: got %h, expected %h", {PC, TAKEN}, {32'h38, 1'b1});
    else pass_cnt++;
    ZERO = 1'b1;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h3C, 1'b0})
      $display("[TB] FAIL bne_not_taken: got %h, expected %h", {PC, TAKEN}, {32'h3C, 1'b0});
    else pass_cnt++;
    BRANCH = 1'b1; BRANCHNOT = 1'b1; ZERO = 1'b0; RD_OFFSET = 8'h01;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h44, 1'b1})
      $display("[TB] FAIL beq_bne_both: got %h, expected %h", {PC, TAKEN}, {32'h44, 1'b1});
    else pass_cnt++;
    BRANCH = 1'b0; BRANCHNOT = 1'b1; JUMP = 1'b1; ZERO = 1'b1; RD_OFFSET = 8'hF0;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h08, 1'b1})
      $display("[TB] FAIL jump_priority: got %h, expected %h", {PC, TAKEN}, {32'h08, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_stall;
    clear_ctrl();
    IMEM_BUSYWAIT = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_cnt++;
      if ({PC, STALL, FETCH_REQ} !== {32'h08, 2'b11})
        $display("[TB] FAIL imem_hold%0d: got %h, expected %h", i, {PC, STALL, FETCH_REQ}, {32'h08, 2'b11});
      else pass_cnt++;
      tick();
    end
    IMEM_BUSYWAIT = 1'b0;
    #1;
    check_cnt++;
    if ({PC, STALL, TAKEN, TIMEOUT_ERR} !== {32'h08, 3'b000})
      $display("[TB] FAIL imem_release: got %h, expected %h", {PC, STALL, TAKEN, TIMEOUT_ERR}, {32'h08, 3'b000});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h0C, 1'b0})
      $display("[TB] FAIL after_stall_pc: got %h, expected %h", {PC, TAKEN}, {32'h0C, 1'b0});
    else pass_cnt++;
    DMEM_BUSYWAIT = 1'b1; BRANCH = 1'b1; ZERO = 1'b1; RD_OFFSET = 8'h01;
    tick();
    check_cnt++;
    if ({PC, TAKEN, STALL} !== {32'h0C, 2'b01})
      $display("[TB] FAIL dmem_hold_branch: got %h, expected %h", {PC, TAKEN, STALL}, {32'h0C, 2'b01});
    else pass_cnt++;
    DMEM_BUSYWAIT = 1'b0;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h14, 1'b1})
      $display("[TB] FAIL stalled_branch_commit: got %h, expected %h", {PC, TAKEN}, {32'h14, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    clear_ctrl();
    JUMP = 1'b1; RD_OFFSET = 8'hF9;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'hFFFF_FFFC, 1'b1})
      $display("[TB] FAIL jump_to_top: got %h, expected %h", {PC, TAKEN}, {32'hFFFF_FFFC, 1'b1});
    else pass_cnt++;
    clear_ctrl();
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h0, 1'b0})
      $display("[TB] FAIL pc_wrap: got %h, expected %h", {PC, TAKEN}, {32'h0, 1'b0});
    else pass_cnt++;
    tick();
    check_cnt++;
    if (PC !== 32'h4) $display("[TB] FAIL post_wrap: got %h, expected %h", PC, 32'h4);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    DMEM_BUSYWAIT = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_cnt++;
      if ({TIMEOUT_ERR, FETCH_REQ, STALL, PC} !== {3'b011, 32'h4})
        $display("[TB] FAIL wdog_stall%0d: got %h, expected %h", i, {TIMEOUT_ERR, FETCH_REQ, STALL, PC}, {3'b011, 32'h4});
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN, PC} !== {4'b1010, 32'h4})
      $display("[TB] FAIL halt_entry: got %h, expected %h", {TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN, PC}, {4'b1010, 32'h4});
    else pass_cnt++;
    DMEM_BUSYWAIT = 1'b0;
    JUMP = 1'b1; RD_OFFSET = 8'h10;
    tick();
    tick();
    check_cnt++;
    if ({TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN, PC} !== {4'b1010, 32'h4})
      $display("[TB] FAIL halt_frozen: got %h, expected %h", {TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN, PC}, {4'b1010, 32'h4});
    else pass_cnt++;
    clear_ctrl();
    #3 RESET = 1'b0;
    #1;
    check_cnt++;
    if ({PC, TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN} !== {32'h0, 4'b0000})
      $display("[TB] FAIL halt_reset: got %h, expected %h", {PC, TIMEOUT_ERR, FETCH_REQ, STALL, TAKEN}, {32'h0, 4'b0000});
    else pass_cnt++;
    #2 RESET = 1'b1;
  endtask

  task automatic test_async_reset_stall;
    tick();
    tick();
    IMEM_BUSYWAIT = 1'b1;
    tick();
    tick();
    check_cnt++;
    if ({PC, STALL} !== {32'h4, 1'b1})
      $display("[TB] FAIL pre_reset_stall: got %h, expected %h", {PC, STALL}, {32'h4, 1'b1});
    else pass_cnt++;
    #4 RESET = 1'b0;
    #1;
    check_cnt++;
    if ({PC, FETCH_REQ, STALL, TAKEN} !== {32'h0, 3'b000})
      $display("[TB] FAIL async_reset_mid_stall: got %h, expected %h", {PC, FETCH_REQ, STALL, TAKEN}, {32'h0, 3'b000});
    else pass_cnt++;
    IMEM_BUSYWAIT = 1'b0;
    #2 RESET = 1'b1;
  endtask

  task automatic test_stats;
    #3 RESET = 1'b0;
    #2 RESET = 1'b1;
    tick();
    tick();
    JUMP = 1'b1; RD_OFFSET = 8'h00;
    tick();
    clear_ctrl();
    DMEM_BUSYWAIT = 1'b1;
    tick();
    DMEM_BUSYWAIT = 1'b0;
    tick();
    check_cnt++;
    if ({PC, TAKEN} !== {32'h0C, 1'b0})
      $display("[TB] FAIL stats_pc: got %h, expected %h", {PC, TAKEN}, {32'h0C, 1'b0});
    else pass_cnt++;
`ifdef BRANCH_STATS_EN
    check_cnt++;
    if ({INSTR_CNT, BR_TAKEN_CNT} !== {16'd3, 16'd1})
      $display("[TB] FAIL stats_counts: got %h, expected %h", {INSTR_CNT, BR_TAKEN_CNT}, {16'd3, 16'd1});
    else pass_cnt++;
`endif
  endtask

  initial begin
    $display("[TB] starting pc_fetch_controller bench");
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_timeout();
    test_async_reset_stall();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequencer for the program-counter datapath of the 8-bit single-cycle CPU. Owns the PC register and holds it while instruction or data memory is busy. Computes and commits the next PC (PC+4, branch or jump target) and runs a stall watchdog. Sits between the control unit/ALU flags and the instruction-memory/cache interface.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
STALL_TIMEOUT, 255, consecutive stalled cycles before HALT; 0 disables the watchdog
CNT_W, 8, width of the stall counter; must satisfy 2^CNT_W > STALL_TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous reset, active-low (0 = reset)
IMEM_BUSYWAIT  in  1  instruction memory not ready
DMEM_BUSYWAIT  in  1  data memory access in progress
BRANCH  in  1  beq-type instruction decoded
BRANCHNOT  in  1  bne-type instruction decoded
JUMP  in  1  unconditional jump decoded
ZERO  in  1  ALU zero flag
RD_OFFSET  in  8  signed word offset, two's complement
PC  out  32  current fetch address
FETCH_REQ  out  1  instruction fetch request
STALL  out  1  PC held this cycle (combinational)
TAKEN  out  1  registered; previous commit was a redirect
TIMEOUT_ERR  out  1  sticky watchdog error

Behaviour:
- Reset (RESET=0, asynchronous): PC=RESET_VECTOR, state=IDLE, FETCH_REQ=0, TAKEN=0, TIMEOUT_ERR=0, stall_cnt=0. Release is sampled at the next CLK rise.
- Next-PC arithmetic:
  - PCPLUS4 = PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - TARGET = PCPLUS4 + (sign-extended RD_OFFSET << 2), modulo 2^32.
  - take = JUMP | (BRANCH & ZERO) | (BRANCHNOT & ~ZERO).
  - NEXTPC = take ? TARGET : PCPLUS4. JUMP has priority; asserting BRANCH and BRANCHNOT together still follows the OR above.
- busy = IMEM_BUSYWAIT | DMEM_BUSYWAIT.
- State IDLE: FETCH_REQ=0, STALL=0. Moves to RUN after 1 cycle. PC is unchanged.
- State RUN: FETCH_REQ=1.
  - busy=0: PC<=NEXTPC, TAKEN<=take, remain in RUN. Latency is one cycle per instruction.
  - busy=1: PC held, TAKEN<=0, stall_cnt<=1, go to STALL.
- State STALL: FETCH_REQ=1, control inputs are assumed stable for the held instruction.
  - busy=0: commit PC<=NEXTPC, TAKEN<=take, stall_cnt<=0, go to RUN.
  - busy=1 and STALL_TIMEOUT!=0 and stall_cnt==STALL_TIMEOUT: go to HALT, TIMEOUT_ERR<=1.
  - Otherwise: stall_cnt<=stall_cnt+1, saturating at all-ones.
- State HALT: FETCH_REQ=0, STALL=1, PC frozen, TAKEN=0. Only reset exits.
- STALL output = (state==RUN|STALL) & busy, or state==HALT.
- Exactly one PC commit per non-stalled cycle; no commit ever occurs while busy=1.
- Reset mid-stall: immediate return to the reset values; stall_cnt is cleared.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: adds outputs BR_TAKEN_CNT[15:0] and INSTR_CNT[15:0].
  - INSTR_CNT increments on each PC commit.
  - BR_TAKEN_CNT increments on each commit with take=1.
  - Both saturate at 16'hFFFF, reset to 0, and freeze in HALT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 4 idle-free cycles, no branch: PC sequence 0 -> 0 (IDLE) -> 4 -> 8 -> 12; FETCH_REQ=1 from cycle 2; TAKEN=0.
- PC=0x10, BRANCH=1, ZERO=1, RD_OFFSET=8'hFE: next PC=0x0C, TAKEN=1. Repeat with ZERO=0: PC=0x14, TAKEN=0.
- PC=0x20, JUMP=1, RD_OFFSET=8'h03: PC=0x30. Also BRANCHNOT=1, ZERO=0, RD_OFFSET=8'h01: PC=PC+8.
- IMEM_BUSYWAIT high for 3 cycles at PC=0x08: PC holds 0x08, STALL=1 for 3 cycles, then PC=0x0C the cycle after release.
- STALL_TIMEOUT=4, DMEM_BUSYWAIT held high: after 4 stalled cycles state=HALT, TIMEOUT_ERR=1, FETCH_REQ=0, PC frozen. Dropping busy has no effect; asserting RESET=0 clears all.
- Wrap and async reset: PC=0xFFFFFFFC with no branch gives PC=0x00000000. Asserting RESET=0 between clock edges while stalled immediately sets PC=RESET_VECTOR. With BRANCH_STATS_EN, INSTR_CNT and BR_TAKEN_CNT match the commit and take counts.
